// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants for the PS/2 mouse init controller: protocol byte values,
// the controller state encoding and the step index width.
// Optional build macro (consumed by the step ROM): PS2_SET_SAMPLE_RATE_EN.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERR      = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] ID_STD       = 8'h00;

  localparam int STEP_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_TX_WAIT,
    S_RESP_WAIT,
    S_BAT_WAIT,
    S_ID_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

endpackage

// File: rtl/ps2_init_step_rom.sv
// ps2_init_step_rom
// Combinational table: step index -> command byte plus reset/last flags.
// Macro PS2_SET_SAMPLE_RATE_EN: when defined the sequence is
// FF, F3, SAMPLE_RATE, F4; otherwise FF, F4.
// Ports:
//   step      in  step index
//   cmd       out command byte for this step
//   is_reset  out step is the mouse reset (expects ACK, BAT, ID)
//   is_last   out final step; completing it finishes the sequence
module ps2_init_step_rom
  import ps2_pkg::*;
#(
`ifdef PS2_SET_SAMPLE_RATE_EN
  parameter logic [7:0] SAMPLE_RATE = 8'd100
`endif
) (
  input  logic [STEP_W-1:0] step,
  output logic [7:0]        cmd,
  output logic              is_reset,
  output logic              is_last
);

  always_comb begin
    cmd      = CMD_ENABLE;
    is_reset = 1'b0;
    is_last  = 1'b0;
`ifdef PS2_SET_SAMPLE_RATE_EN
    case (step)
      2'd0:    begin cmd = CMD_RESET; is_reset = 1'b1; end
      2'd1:    cmd = CMD_SET_RATE;
      2'd2:    cmd = SAMPLE_RATE;
      default: begin cmd = CMD_ENABLE; is_last = 1'b1; end
    endcase
`else
    case (step)
      2'd0:    begin cmd = CMD_RESET; is_reset = 1'b1; end
      default: begin cmd = CMD_ENABLE; is_last = 1'b1; end
    endcase
`endif
  end

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
// Brings a PS/2 mouse from power-up into stream mode: sends reset, waits for
// ACK/BAT/ID, then enables data reporting. Handles resend, timeouts and a
// bounded number of retries per command.
// Macro PS2_SET_SAMPLE_RATE_EN adds the set-sample-rate steps (see step ROM).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle request to (re)run the sequence
//   tx_data, tx_start   command byte and launch pulse to the transmitter
//   tx_busy/ack/error   transmitter status
//   rx_data, rx_valid   received byte stream
//   init_done/fail      sequence outcome levels
//   retry_cnt           retries consumed on the current command
//   ctrl_busy           sequence in progress
//
// state       | meaning
// S_IDLE      | waiting for start
// S_LAUNCH    | waiting for transmitter idle, then pulse tx_start
// S_TX_WAIT   | byte on the wire; wait for tx_busy to fall
// S_RESP_WAIT | waiting for the command response (ACK/resend)
// S_BAT_WAIT  | reset acknowledged; waiting for self-test pass
// S_ID_WAIT   | waiting for the device ID byte
// S_DONE      | mouse streaming; rx bytes belong to the packet decoder
// S_FAIL      | retries exhausted
module ps2_mouse_init_ctrl
  import ps2_pkg::*;
#(
  parameter int RESP_TIMEOUT = 540000,
  parameter int BAT_TIMEOUT  = 27000000,
  parameter int MAX_RETRIES  = 3,
  parameter int TIMER_W      = 25
`ifdef PS2_SET_SAMPLE_RATE_EN
  ,
  parameter logic [7:0] SAMPLE_RATE = 8'd100
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_ack,
  input  logic       tx_error,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       init_done,
  output logic       init_fail,
  output logic [1:0] retry_cnt,
  output logic       ctrl_busy
);

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [TIMER_W-1:0]  timer;
  logic                pend_vld;
  logic [7:0]          pend_data;
  logic                tx_busy_q;

  logic [7:0]          step_cmd;
  logic                step_is_reset;
  logic                step_is_last;

  logic                rsp_vld;
  logic [7:0]          rsp_byte;
  logic                resp_enter, bat_enter, id_enter, next_req, retry_req;

  ps2_init_step_rom
`ifdef PS2_SET_SAMPLE_RATE_EN
    #(.SAMPLE_RATE(SAMPLE_RATE))
`endif
  u_rom (
    .step     (step),
    .cmd      (step_cmd),
    .is_reset (step_is_reset),
    .is_last  (step_is_last)
  );

  // A byte that arrived while the command was still on the wire is served
  // first; a live byte in the same cycle would be lost, but the device never
  // sends two bytes that close together.
  assign rsp_vld  = pend_vld | rx_valid;
  assign rsp_byte = pend_vld ? pend_data : rx_data;

  always_comb begin
    resp_enter = 1'b0;
    bat_enter  = 1'b0;
    id_enter   = 1'b0;
    next_req   = 1'b0;
    retry_req  = 1'b0;
    case (state)
      S_TX_WAIT: begin
        if (tx_busy_q && !tx_busy) begin
          if (tx_ack && !tx_error) resp_enter = 1'b1;
          else                     retry_req  = 1'b1;
        end
      end
      S_RESP_WAIT: begin
        if (rsp_vld) begin
          if (rsp_byte == RSP_ACK) begin
            if (step_is_reset) bat_enter = 1'b1;
            else               next_req  = 1'b1;
          end else begin
            retry_req = 1'b1;  // resend request or garbage
          end
        end else if (timer == '0) begin
          retry_req = 1'b1;
        end
      end
      S_BAT_WAIT: begin
        if (rx_valid && rx_data == RSP_BAT_OK)                       id_enter  = 1'b1;
        else if ((rx_valid && rx_data == RSP_ERR) || timer == '0)    retry_req = 1'b1;
      end
      S_ID_WAIT: begin
        if (rx_valid) begin
          if (rx_data == ID_STD) next_req  = 1'b1;
          else                   retry_req = 1'b1;
        end else if (timer == '0) begin
          retry_req = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step      <= '0;
      timer     <= '0;
      pend_vld  <= 1'b0;
      pend_data <= 8'h00;
      tx_busy_q <= 1'b0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      init_done <= 1'b0;
      init_fail <= 1'b0;
      retry_cnt <= 2'd0;
      ctrl_busy <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      tx_busy_q <= tx_busy;
      if (timer != '0) timer <= timer - {{(TIMER_W-1){1'b0}}, 1'b1};

      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            step      <= '0;
            retry_cnt <= 2'd0;
            init_done <= 1'b0;
            init_fail <= 1'b0;
            ctrl_busy <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!tx_busy) begin
            tx_data  <= step_cmd;
            tx_start <= 1'b1;
            pend_vld <= 1'b0;
            state    <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (rx_valid && !pend_vld) begin
            pend_vld  <= 1'b1;
            pend_data <= rx_data;
          end
          if (resp_enter) begin
            timer <= TIMER_W'(RESP_TIMEOUT);
            state <= S_RESP_WAIT;
          end
        end
        S_RESP_WAIT: begin
          pend_vld <= 1'b0;
          if (bat_enter) begin
            timer <= TIMER_W'(BAT_TIMEOUT);
            state <= S_BAT_WAIT;
          end
        end
        S_BAT_WAIT: begin
          if (id_enter) begin
            timer <= TIMER_W'(RESP_TIMEOUT);
            state <= S_ID_WAIT;
          end
        end
        default: ;
      endcase

      if (next_req) begin
        retry_cnt <= 2'd0;
        if (step_is_last) begin
          init_done <= 1'b1;
          ctrl_busy <= 1'b0;
          state     <= S_DONE;
        end else begin
          step  <= step + 1'b1;
          state <= S_LAUNCH;
        end
      end

      if (retry_req) begin
        if (retry_cnt == 2'(MAX_RETRIES)) begin
          init_fail <= 1'b1;
          ctrl_busy <= 1'b0;
          state     <= S_FAIL;
        end else begin
          retry_cnt <= retry_cnt + 1'b1;
          state     <= S_LAUNCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb_ps2_mouse_init_ctrl
// Drives the init controller with a scripted mouse/transmitter model. Each
// launch gets a reply kind (good, early ACK, resend, line error, silence,
// bad byte, BAT timeout, bad ID); the expected command order, retry counts
// and final outcome come from a transaction-level model of the sequencing
// rules. Honours PS2_SET_SAMPLE_RATE_EN for the expected command list.
module tb_ps2_mouse_init_ctrl;

  localparam int RT = 40;
  localparam int BT = 120;

  localparam int K_OK      = 0;
  localparam int K_EARLY   = 1;
  localparam int K_RESEND  = 2;
  localparam int K_LINEERR = 3;
  localparam int K_NOREPLY = 4;
  localparam int K_BADBYTE = 5;
  localparam int K_BATTO   = 6;
  localparam int K_BADID   = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       tx_ack = 1'b0;
  logic       tx_error = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       init_done;
  logic       init_fail;
  logic [1:0] retry_cnt;
  logic       ctrl_busy;

  ps2_mouse_init_ctrl #(
    .RESP_TIMEOUT (RT),
    .BAT_TIMEOUT  (BT),
    .MAX_RETRIES  (3),
    .TIMER_W      (25)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_ack    (tx_ack),
    .tx_error  (tx_error),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .init_done (init_done),
    .init_fail (init_fail),
    .retry_cnt (retry_cnt),
    .ctrl_busy (ctrl_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miscmp = 0;
  int cyc = 0;
  int starts_seen = 0;
  logic [7:0] cmds[$];
  int plan[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_start) starts_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {tx_data, tx_start, init_done, init_fail, retry_cnt, ctrl_busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; tx_busy = 1'b0; tx_ack = 1'b0;
    tx_error = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    chk_outs_zero("reset_outs");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_launch(output bit got);
    got = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (tx_start) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Mouse + transmitter behaviour for one launch; called on the negedge
  // where tx_start is seen. Returns the cycle stamp of the tx_busy fall.
  task automatic serve_launch(input int kind, input bit is_rst, output int t_fall);
    logic [7:0] bytes[$];
    bit early, line_err;
    int nb;
    early = (kind == K_EARLY);
    line_err = (kind == K_LINEERR);
    case (kind)
      K_OK:      if (is_rst) bytes = '{8'hFA, 8'hAA, 8'h00}; else bytes = '{8'hFA};
      K_EARLY:   if (is_rst) bytes = '{8'hAA, 8'h00};
      K_RESEND:  bytes = '{8'hFE};
      K_BADBYTE: if (is_rst) bytes = '{8'hFA, 8'hFC}; else bytes = '{8'h55};
      K_BATTO:   if (is_rst) bytes = '{8'hFA};
      K_BADID:   if (is_rst) bytes = '{8'hFA, 8'hAA, 8'h03}; else bytes = '{8'h12};
      default:   ;
    endcase
    tx_busy = 1'b1;
    @(negedge clk);
    chk("tx_start_one_cycle", tx_start, 1'b0);
    nb = $urandom_range(2, 6);
    for (int i = 0; i < nb; i++) begin
      if (early && i == 0) begin rx_valid = 1'b1; rx_data = 8'hFA; end
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'h00;
    end
    tx_busy = 1'b0;
    if (line_err) tx_error = 1'b1; else tx_ack = 1'b1;
    t_fall = cyc;
    @(negedge clk);
    tx_ack = 1'b0; tx_error = 1'b0;
    foreach (bytes[i]) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      send_byte(bytes[i]);
    end
  endtask

  // Transaction-level model: each launch either succeeds (advance step,
  // clear retries) or fails (retry or give up after three retries).
  task automatic run_trial(input string name);
    int step, retries, launches, base, k, t_fall, prev_kind, prev_fall, d;
    bit finished, exp_done, got, prev_rst;
    do_reset();
    base = starts_seen;
    pulse_start();
    chk({name, "_busy"}, ctrl_busy, 1'b1);
    step = 0; retries = 0; launches = 0; finished = 0; exp_done = 0;
    prev_kind = -1; prev_fall = 0; prev_rst = 0;
    while (!finished) begin
      wait_launch(got);
      if (!got) begin
        chk({name, "_launch_wait"}, got, 1'b1);
        return;
      end
      if (prev_kind == K_NOREPLY && !prev_rst) begin
        d = cyc - prev_fall;
        chk({name, "_timeout_gap"}, (d >= RT + 2 && d <= RT + 4), 1'b1);
      end
      launches++;
      chk({name, "_tx_data"}, tx_data, cmds[step]);
      chk({name, "_retry_cnt"}, retry_cnt, retries);
      k = (plan.size() > 0) ? plan.pop_front() : K_OK;
      prev_kind = k; prev_rst = (step == 0);
      serve_launch(k, step == 0, t_fall);
      prev_fall = t_fall;
      if (k == K_OK || k == K_EARLY) begin
        retries = 0;
        step++;
        if (step == cmds.size()) begin finished = 1; exp_done = 1; end
      end else if (retries == 3) begin
        finished = 1;
      end else begin
        retries++;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!ctrl_busy) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({name, "_end_wait"}, got, 1'b1);
    repeat (20) @(negedge clk);
    chk({name, "_init_done"}, init_done, exp_done);
    chk({name, "_init_fail"}, init_fail, !exp_done);
    chk({name, "_final_retry"}, retry_cnt, exp_done ? 0 : 3);
    chk({name, "_launches"}, starts_seen - base, launches);
  endtask

  initial begin
    int base;
    bit got;
`ifdef PS2_SET_SAMPLE_RATE_EN
    cmds = '{8'hFF, 8'hF3, 8'd100, 8'hF4};
`else
    cmds = '{8'hFF, 8'hF4};
`endif
    repeat (2) @(negedge clk);

    plan = '{};
    run_trial("nominal");
    plan = '{K_OK, K_RESEND, K_OK};
    run_trial("resend");
    plan = '{K_OK, K_NOREPLY, K_NOREPLY, K_NOREPLY, K_NOREPLY};
    run_trial("timeout");
    plan = '{K_BADBYTE, K_OK, K_OK};
    run_trial("bat_fail");
    plan = '{K_EARLY, K_EARLY};
    run_trial("early");

    // Reset while waiting for the first response.
    do_reset();
    pulse_start();
    wait_launch(got);
    chk("midrst_launch", got, 1'b1);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0; tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_outs_zero("midrst_outs");
    base = starts_seen;
    repeat (RT * 3) @(negedge clk);
    chk("midrst_no_launch", starts_seen - base, 0);
    chk_outs_zero("midrst_idle");

    for (int t = 0; t < 25; t++) begin
      plan = '{};
      for (int j = 0; j < 8; j++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r <= 6 || r == 15) plan.push_back(K_OK);
        else if (r <= 8)       plan.push_back(K_EARLY);
        else                   plan.push_back(r - 7);
      end
      run_trial($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
- Sequences the PS/2 host-to-device transmitter and monitors the PS/2 receive byte stream to bring a mouse from power-up into stream mode.
- Command flow: reset (0xFF), wait ACK/BAT/ID, then enable data reporting (0xF4).
- Handles resend requests, timeouts and bounded retries.
- Sits between the top-level Paint controller and the PS/2 TX/RX pair; asserts `init_done` when packets may be consumed.

Parameters:
- RESP_TIMEOUT, 540000, cycles to wait for each response byte (20 ms @ 27 MHz)
- BAT_TIMEOUT, 27000000, cycles to wait for BAT 0xAA after reset ACK (1 s @ 27 MHz)
- MAX_RETRIES, 3, retries per command before FAIL
- TIMER_W, 25, timer width; must hold max(RESP_TIMEOUT, BAT_TIMEOUT)
- SAMPLE_RATE, 8'd100, rate byte sent when the optional feature is compiled in

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to (re)run the init sequence
- tx_data  out  8  command byte to transmitter
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_busy  in  1  transmitter busy
- tx_ack  in  1  transmitter saw device line-level ACK
- tx_error  in  1  transmitter saw no line ACK
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- init_done  out  1  level; mouse in stream mode
- init_fail  out  1  level; retries exhausted
- retry_cnt  out  2  retries consumed on current command
- ctrl_busy  out  1  sequence in progress

Behaviour:
- Reset (rst_n low at posedge clk):
  - All outputs 0: tx_data=8'h00, tx_start, init_done, init_fail, retry_cnt, ctrl_busy.
  - State IDLE; timer, step and pending flag cleared.
  - Reset mid-operation aborts immediately; the transmitter is left to finish on its own.
- States: IDLE, LAUNCH, TX_WAIT, RESP_WAIT, BAT_WAIT, ID_WAIT, DONE, FAIL.
- IDLE / DONE / FAIL:
  - start=1 -> step=0, retry_cnt=0, init_done=0, init_fail=0, ctrl_busy=1, go LAUNCH.
  - start while ctrl_busy=1 is ignored.
- LAUNCH:
  - If tx_busy=0: drive tx_data=cmd[step], tx_start=1 for exactly one cycle, go TX_WAIT.
  - Otherwise hold.
- TX_WAIT:
  - Wait for a falling edge of tx_busy (registered prev).
  - tx_error at that edge -> retry.
  - tx_ack -> load timer=RESP_TIMEOUT, go RESP_WAIT.
  - An rx_valid seen while in TX_WAIT is latched in a 1-entry pending register and consumed on the first RESP_WAIT cycle.
- RESP_WAIT (timer decrements each cycle):
  - 0xFA -> if step=0 (reset): timer=BAT_TIMEOUT, go BAT_WAIT; else next step.
  - 0xFE -> resend same cmd, counted as a retry.
  - Any other byte, or timer=0 -> retry.
- BAT_WAIT:
  - 0xAA -> timer=RESP_TIMEOUT, go ID_WAIT.
  - 0xFC or timeout -> retry (reset step).
  - Other bytes are ignored.
- ID_WAIT:
  - 0x00 -> next step.
  - Any other byte or timeout -> retry.
- Next step:
  - retry_cnt=0, step+1; if past the last step -> DONE (init_done=1, ctrl_busy=0), else LAUNCH.
- Retry:
  - If retry_cnt==MAX_RETRIES -> FAIL (init_fail=1, ctrl_busy=0).
  - Else retry_cnt+1 and go LAUNCH with the same step.
- Timer: saturates at 0; compares are against 0 only.
- In DONE, rx bytes are ignored; they belong to the packet decoder.
- Latency: tx_start asserts 1 cycle after entering LAUNCH with tx_busy=0.
- Simultaneous rx_valid and timer=0: the byte wins.

Optional Feature:
- Macro: PS2_SET_SAMPLE_RATE_EN
- Defined: the step list is FF, F3, SAMPLE_RATE, F4; each non-reset step expects 0xFA.
- Undefined: the step list is FF, F4, and the SAMPLE_RATE parameter is unused.

Decomposition:
- Package ps2_pkg:
  - Byte constants: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_RATE=8'hF3, RSP_ACK=8'hFA, RSP_RESEND=8'hFE, RSP_ERR=8'hFC, RSP_BAT_OK=8'hAA, ID_STD=8'h00.
  - State encoding.
- Sub-module ps2_init_step_rom: combinational step index -> {cmd byte, is_reset, is_last}. It honours the macro.

Test Plan:
- Nominal: start; model acks each tx, returns FA, AA, 00, then FA to F4 -> exactly 2 tx_start pulses (FF, F4); init_done=1; retry_cnt=0.
- Resend: reply FE to F4 once, then FA -> F4 sent twice; retry_cnt=1 before DONE; init_done=1.
- Timeout: no reply to F4 -> F4 launched 4 times, RESP_TIMEOUT apart; then init_fail=1, init_done=0.
- BAT fail: FA then FC after reset -> FF resent; second attempt FA, AA, 00 -> continues to F4.
- Early response: rx_valid=FA while tx_busy is still 1 -> byte is latched and the step advances without a timeout.
- Reset mid RESP_WAIT: rst_n low 1 cycle -> all outputs 0, state IDLE; no tx_start until the next start.
